// File: rtl/branch_resolve.sv
// Resolves conditional branches and jumps one cycle after accept. After a taken
// result it squashes for SQUASH_CYC cycles and keeps branch/taken statistics.
module branch_resolve #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 32,
  parameter int          OFF_W      = 16,
  parameter int          SQUASH_CYC = 2,
  parameter int          CNT_W      = 16,
  parameter logic [5:0]  BRA_OPC    = 6'b10110,
  parameter logic [5:0]  JUMP_OPC   = 6'b10101
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VALID_IN,
  input  logic              STALL,
  input  logic [5:0]        OPC,
  input  logic [2:0]        COND,
  input  logic [DATA_W-1:0] RS1,
  input  logic [DATA_W-1:0] RSVAL,
  input  logic [ADDR_W-1:0] PC,
  input  logic [OFF_W-1:0]  OFFSET,
  input  logic              CLR_CNT,
  output logic              VALID_OUT,
  output logic              TAKEN,
  output logic              NOT_TAKEN,
  output logic [ADDR_W-1:0] TARGET,
  output logic              SQUASH,
  output logic [CNT_W-1:0]  BR_CNT,
  output logic [CNT_W-1:0]  TK_CNT
);

  typedef enum logic {ST_RUN, ST_SQUASH} state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_sq_cnt, w_sq_cnt_nxt;
  logic                r_valid, r_taken, r_not_taken;
  logic [ADDR_W-1:0]   r_target;
  logic [CNT_W-1:0]    r_br_cnt, r_tk_cnt;

  logic                w_is_bra, w_is_jmp, w_cond_true, w_taken, w_accept;
  logic [ADDR_W-1:0]   w_target;

  assign w_is_bra = (OPC == BRA_OPC);
  assign w_is_jmp = (OPC == JUMP_OPC);
  assign w_accept = VALID_IN && !STALL && (r_state == ST_RUN) && (w_is_bra || w_is_jmp);
  assign w_taken  = w_is_jmp || w_cond_true;
  // Size cast of a signed operand sign-extends the displacement; the add wraps.
  assign w_target = PC + ADDR_W'($signed(OFFSET));

  always_comb begin
    w_cond_true = 1'b0;
    case (COND)
      3'b000:  w_cond_true = (RS1 == RSVAL);
      3'b001:  w_cond_true = (RS1 != RSVAL);
      3'b010:  w_cond_true = ($signed(RS1) <  $signed(RSVAL));
      3'b011:  w_cond_true = ($signed(RS1) >= $signed(RSVAL));
      3'b100:  w_cond_true = (RS1 <  RSVAL);
      3'b101:  w_cond_true = (RS1 >= RSVAL);
      3'b110:  w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    if (!STALL) begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && w_taken) begin
            w_state_nxt  = ST_SQUASH;
            w_sq_cnt_nxt = 4'(SQUASH_CYC);
          end
        end
        default: begin
          w_sq_cnt_nxt = r_sq_cnt - 4'd1;
          if (r_sq_cnt <= 4'd1) begin
            w_state_nxt  = ST_RUN;
            w_sq_cnt_nxt = 4'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid     <= 1'b0;
      r_taken     <= 1'b0;
      r_not_taken <= 1'b0;
      r_target    <= '0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_taken     <= w_taken;
      r_not_taken <= !w_taken;
      r_target    <= w_target;
    end else if (!STALL) begin
      r_valid     <= 1'b0;
      r_taken     <= 1'b0;
      r_not_taken <= 1'b0;
    end
  end

  // Clear is independent of STALL and beats a same-cycle increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_br_cnt <= '0;
      r_tk_cnt <= '0;
    end else if (CLR_CNT) begin
      r_br_cnt <= '0;
      r_tk_cnt <= '0;
    end else if (w_accept) begin
      if (r_br_cnt != '1)            r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_taken && r_tk_cnt != '1) r_tk_cnt <= r_tk_cnt + CNT_W'(1);
    end
  end

  assign VALID_OUT = r_valid;
  assign TAKEN     = r_taken;
  assign NOT_TAKEN = r_not_taken;
  assign TARGET    = r_target;
  assign SQUASH    = (r_state == ST_SQUASH);
  assign BR_CNT    = r_br_cnt;
  assign TK_CNT    = r_tk_cnt;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DATA_W, default 32: comparand width.
REQ-002 SHALL have parameter ADDR_W, default 32: PC and target width.
REQ-003 SHALL have parameter OFF_W, default 16: branch offset width, two's complement.
REQ-004 SHALL have parameter SQUASH_CYC, default 2: post-redirect squash length, 1..15.
REQ-005 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-006 SHALL have parameters BRA_OPC = 6'b10110 and JUMP_OPC = 6'b10101.
REQ-007 Ports: CLK in 1, the single clock; reset is asynchronous and active-high.
REQ-008 Ports: RST in 1, asynchronous active-high reset.
REQ-009 Ports: VALID_IN in 1, an instruction is presented.
REQ-010 Ports: STALL in 1, freeze pipeline.
REQ-011 Ports: OPC in 6, opcode.
REQ-012 Ports: COND in 3, compare mode.
REQ-013 Ports: RS1 in DATA_W, first operand.
REQ-014 Ports: RSVAL in DATA_W, second operand.
REQ-015 Ports: PC in ADDR_W, instruction address.
REQ-016 Ports: OFFSET in OFF_W, branch displacement.
REQ-017 Ports: CLR_CNT in 1, synchronous statistics clear.
REQ-018 Ports: VALID_OUT out 1, resolved branch/jump.
REQ-019 Ports: TAKEN out 1; NOT_TAKEN out 1.
REQ-020 Ports: TARGET out ADDR_W, redirect address.
REQ-021 Ports: SQUASH out 1, high while in SQUASH state.
REQ-022 Ports: BR_CNT out CNT_W; TK_CNT out CNT_W.

Function
REQ-023 COND encoding SHALL be: 000 EQ, 001 NE, 010 LT signed, 011 GE signed, 100 LTU, 101 GEU, 110 always, 111 never; compare is RS1 op RSVAL.
REQ-024 OPC==JUMP_OPC SHALL be taken regardless of COND; other opcodes SHALL produce no result (VALID_OUT=0).
REQ-025 TARGET SHALL be PC + sign-extended OFFSET, modulo 2^ADDR_W (wraps, no flag).
REQ-026 Accept condition: rising CLK with VALID_IN=1, STALL=0, state RUN, OPC in {BRA_OPC, JUMP_OPC}.
REQ-027 On accept, next cycle: VALID_OUT=1, exactly one of TAKEN/NOT_TAKEN=1, TARGET registered; latency 1 cycle.
REQ-028 Without accept and STALL=0, VALID_OUT/TAKEN/NOT_TAKEN SHALL be 0 next cycle; TARGET holds its last value.
REQ-029 STALL=1 SHALL hold all output registers, the FSM state and the squash counter unchanged.
REQ-030 FSM states SHALL be RUN and SQUASH; RUN->SQUASH on accepting a taken result, loading counter with SQUASH_CYC.
REQ-031 In SQUASH, the counter SHALL decrement each non-stalled cycle; the FSM SHALL return to RUN on the cycle the counter reaches 0.
REQ-032 In SQUASH, VALID_IN SHALL be ignored: no result, no counter increment.
REQ-033 BR_CNT SHALL increment on each accept; TK_CNT SHALL increment on each taken accept; both saturate at all-ones.
REQ-034 CLR_CNT=1 SHALL zero both counters next edge; it SHALL win over a simultaneous increment and SHALL act even during STALL.
REQ-035 Not-taken accepts SHALL keep the FSM in RUN; back-to-back accepts SHALL resolve one per cycle.

Reset
REQ-036 RST=1 SHALL asynchronously force VALID_OUT, TAKEN, NOT_TAKEN, SQUASH=0, TARGET=0, BR_CNT=TK_CNT=0, state RUN, squash counter 0.
REQ-037 RST mid-squash SHALL abort the squash; the first accept after deassertion SHALL resolve normally.

Verification
REQ-038 BRA, COND=000, RS1=RSVAL=0x5, PC=0x100, OFFSET=0x0010 -> next cycle VALID_OUT=1, TAKEN=1, TARGET=0x110, SQUASH=1 for 2 cycles.
REQ-039 BRA, COND=010, RS1=0xFFFFFFFF, RSVAL=0x1 -> TAKEN=1; same operands with COND=100 -> NOT_TAKEN=1.
REQ-040 JUMP, PC=0x00000004, OFFSET=0xFFF8 -> TAKEN=1, TARGET=0xFFFFFFFC (wrap).
REQ-041 Taken BRA followed by two valid BRAs during SQUASH -> neither resolves; BR_CNT=1, TK_CNT=1.
REQ-042 STALL=1 for 3 cycles during SQUASH -> SQUASH stays 1 for 5 cycles total; outputs frozen.
REQ-043 CNT_W=4, 16 taken JUMPs with SQUASH_CYC=1 -> counters saturate at 0xF; CLR_CNT concurrent with an accept -> both 0.
